// File: rtl/karatsuba_mul_arbiter.sv
// Two-requester round-robin front end for one shared
// iterative 32x32 Karatsuba multiplier, with hang timeout.
module karatsuba_mul_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [63:0] resp_data,
    output logic        resp_err,
    input  logic        resp_ready,
    output logic        mul_rst,
    output logic        mul_enable,
    output logic [31:0] mul_A,
    output logic [31:0] mul_B,
    input  logic [63:0] mul_C,
    input  logic        mul_done,
    output logic        busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic          id_q, id_d;
    logic [63:0]   data_q, data_d;
    logic          err_q, err_d;
    logic          rv_q, rv_d;
    logic          mrst_q, mrst_d;
    logic          men_q, men_d;
    logic          busy_q, busy_d;
    logic          gnt0, gnt1;

    // Round-robin winner: a lone requester wins, ties go to ptr
    always_comb begin
        gnt1 = req1_valid && (!req0_valid || ptr_q);
        gnt0 = req0_valid && !gnt1;
    end

    assign req0_ready = (state_q == S_IDLE) && gnt0;
    assign req1_ready = (state_q == S_IDLE) && gnt1;

    assign resp_valid = rv_q;
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign resp_err   = err_q;
    assign mul_rst    = mrst_q;
    assign mul_enable = men_q;
    assign mul_A      = a_q;
    assign mul_B      = b_q;
    assign busy       = busy_q;

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        data_d  = data_q;
        err_d   = err_q;
        rv_d    = 1'b0;
        mrst_d  = 1'b0;
        men_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d     = gnt1 ? req1_a : req0_a;
                    b_d     = gnt1 ? req1_b : req0_b;
                    id_d    = gnt1;
                    ptr_d   = !gnt1;
                    mrst_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                men_d   = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (mul_done) begin
                    data_d  = mul_C;
                    err_d   = 1'b0;
                    rv_d    = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    rv_d    = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    men_d = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    rv_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rv_q    <= 1'b0;
            mrst_q  <= 1'b1;
            men_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            data_q  <= data_d;
            err_q   <= err_d;
            rv_q    <= rv_d;
            mrst_q  <= mrst_d;
            men_q   <= men_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_karatsuba_mul_arbiter.sv
// Bench for karatsuba_mul_arbiter: behavioural multiplier model,
// vector table, scoreboard and hand-written corner sequences.
module tb_karatsuba_mul_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_id, resp_err, resp_ready;
    logic [63:0] resp_data;
    logic        mul_rst, mul_enable, mul_done;
    logic [31:0] mul_A, mul_B;
    logic [63:0] mul_C;
    logic        busy;

    karatsuba_mul_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a),
        .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a),
        .req1_b(req1_b), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err),
        .resp_ready(resp_ready),
        .mul_rst(mul_rst), .mul_enable(mul_enable),
        .mul_A(mul_A), .mul_B(mul_B),
        .mul_C(mul_C), .mul_done(mul_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural iterative multiplier with settable latency
    int          mul_lat;
    int          mcnt;
    logic        mdone;
    logic        tie_off;
    logic        force_done;
    assign mul_done = mdone | force_done;

    always @(posedge clk) begin
        if (mul_rst) begin
            mcnt  <= 0;
            mdone <= 1'b0;
            mul_C <= '0;
        end else if (mul_enable && !mdone && !tie_off) begin
            if (mcnt + 1 >= mul_lat) begin
                mdone <= 1'b1;
                mul_C <= {32'b0, mul_A} * {32'b0, mul_B};
            end
            mcnt <= mcnt + 1;
        end else if (!mul_enable) begin
            mdone <= 1'b0;
        end
    end

    typedef struct {
        logic        id;
        logic [63:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    exp_t        sb[$];
    logic        grants[$];
    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    int          n_resp = 0;
    int          grant_limit;
    logic        hold0, hold1;
    logic [63:0] exp0, exp1;
    logic        exp0_err;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock: observe at negedge, update drive after posedge
    task automatic tick();
        logic acc0, acc1;
        exp_t e;
        acc0 = 1'b0;
        acc1 = 1'b0;
        @(negedge clk);
        if (!rst) begin
            if (req0_valid && req0_ready) begin
                grants.push_back(1'b0);
                sb.push_back('{1'b0, exp0, exp0_err});
                acc0 = 1'b1;
            end
            if (req1_valid && req1_ready) begin
                grants.push_back(1'b1);
                sb.push_back('{1'b1, exp1, 1'b0});
                acc1 = 1'b1;
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    chk("resp_data", resp_data, e.data);
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                end
                n_resp++;
            end
        end
        @(posedge clk);
        #1;
        if (acc0 && !hold0) req0_valid = 1'b0;
        if (acc1 && !hold1) req1_valid = 1'b0;
        if (grant_limit > 0 && grants.size() >= grant_limit) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic wait_resps(int target);
        int k;
        k = 0;
        while (n_resp < target && k < 300) begin
            tick();
            k++;
        end
        chk("resp_count", 64'(n_resp), 64'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        grants.delete();
    endtask

    initial begin
        int   n;
        int   seen_rv;
        logic seen;

        vecs[0] = '{1'b0, 32'd3, 32'd5, 64'd15};
        vecs[1] = '{1'b1, 32'd2, 32'd7, 64'd14};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    64'hFFFF_FFFE_0000_0001};
        vecs[3] = '{1'b1, 32'd0, 32'd123, 64'd0};
        vecs[4] = '{1'b0, 32'h0001_0000, 32'h0001_0000,
                    64'h1_0000_0000};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd2, 64'h1_FFFF_FFFE};

        rst         = 1'b1;
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        req0_a      = '0;
        req0_b      = '0;
        req1_a      = '0;
        req1_b      = '0;
        resp_ready  = 1'b1;
        tie_off     = 1'b0;
        force_done  = 1'b0;
        mul_lat     = 3;
        grant_limit = 0;
        hold0       = 1'b0;
        hold1       = 1'b0;
        exp0        = '0;
        exp1        = '0;
        exp0_err    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mul_rst", 64'(mul_rst), 64'd1);
        chk("rst_mul_en", 64'(mul_enable), 64'd0);
        chk("rst_mul_A", 64'(mul_A), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_mul_rst", 64'(mul_rst), 64'd0);
        chk("post_rst_ready0", 64'(req0_ready), 64'd0);

        // stray mul_done while idle is ignored
        force_done = 1'b1;
        tick();
        tick();
        force_done = 1'b0;
        chk("idle_done_busy", 64'(busy), 64'd0);
        chk("idle_done_rv", 64'(resp_valid), 64'd0);

        // single-requester vectors
        for (int i = 0; i < 6; i++) begin
            mul_lat = 1 + (i % 4);
            if (vecs[i].id) begin
                req1_a = vecs[i].a;
                req1_b = vecs[i].b;
                exp1 = vecs[i].p;
                req1_valid = 1'b1;
            end else begin
                req0_a = vecs[i].a;
                req0_b = vecs[i].b;
                exp0 = vecs[i].p;
                req0_valid = 1'b1;
            end
            wait_resps(n_resp + 1);
        end

        // simultaneous requests after reset: id0 first
        do_reset();
        mul_lat = 2;
        req0_a = 32'hFFFF_FFFF;
        req0_b = 32'hFFFF_FFFF;
        exp0 = 64'hFFFF_FFFE_0000_0001;
        req1_a = 32'd2;
        req1_b = 32'd7;
        exp1 = 64'd14;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_resps(n_resp + 2);
        chk("both_grant_cnt", 64'(grants.size()), 64'd2);
        if (grants.size() >= 2) begin
            chk("both_grant0", 64'(grants[0]), 64'd0);
            chk("both_grant1", 64'(grants[1]), 64'd1);
        end

        // continuous contention alternates
        do_reset();
        req0_a = 32'd3;
        req0_b = 32'd5;
        exp0 = 64'd15;
        grant_limit = 4;
        hold0 = 1'b1;
        hold1 = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_resps(n_resp + 4);
        chk("rr_grant_cnt", 64'(grants.size()), 64'd4);
        if (grants.size() >= 4) begin
            for (int i = 0; i < 4; i++)
                chk("rr_grant", 64'(grants[i]), 64'(i % 2));
        end
        grant_limit = 0;
        hold0 = 1'b0;
        hold1 = 1'b0;

        // back-pressure in RESP
        resp_ready = 1'b0;
        req0_a = 32'hDEAD_BEEF;
        req0_b = 32'h10;
        exp0 = 64'hD_EADB_EEF0;
        req0_valid = 1'b1;
        n = 0;
        while (!resp_valid && n < 60) begin
            tick();
            n++;
        end
        chk("stall_reach", 64'(resp_valid), 64'd1);
        req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_rv", 64'(resp_valid), 64'd1);
            chk("stall_data", resp_data, 64'hD_EADB_EEF0);
            chk("stall_id", 64'(resp_id), 64'd0);
            chk("stall_rdy", 64'({req0_ready, req1_ready}), 64'd0);
        end
        resp_ready = 1'b1;
        wait_resps(n_resp + 2);

        // hung multiplier times out
        do_reset();
        tie_off = 1'b1;
        exp0 = 64'd0;
        exp0_err = 1'b1;
        req0_valid = 1'b1;
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (seen) n++;
            if (!seen && mul_enable) seen = 1'b1;
            if (resp_valid) break;
        end
        chk("to_cycles", 64'(n), 64'(TO));
        chk("to_err", 64'(resp_err), 64'd1);
        chk("to_data", resp_data, 64'd0);
        wait_resps(n_resp + 1);
        tie_off = 1'b0;
        exp0_err = 1'b0;

        // reset mid-RUN discards the result
        do_reset();
        mul_lat = 10;
        req0_a = 32'd3;
        req0_b = 32'd5;
        exp0 = 64'd15;
        req0_valid = 1'b1;
        n = 0;
        while (!mul_enable && n < 20) begin
            tick();
            n++;
        end
        chk("mid_run_reach", 64'(mul_enable), 64'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rv", 64'(resp_valid), 64'd0);
        chk("mid_rst_en", 64'(mul_enable), 64'd0);
        chk("mid_rst_mrst", 64'(mul_rst), 64'd1);
        rst = 1'b0;
        sb.delete();
        grants.delete();
        seen_rv = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (resp_valid) seen_rv++;
        end
        chk("mid_rst_no_resp", 64'(seen_rv), 64'd0);
        mul_lat = 2;
        req1_a = 32'd2;
        req1_b = 32'd7;
        exp1 = 64'd14;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        wait_resps(n_resp + 2);
        chk("mid_rst_grant_cnt", 64'(grants.size()), 64'd2);
        if (grants.size() >= 1)
            chk("mid_rst_ptr", 64'(grants[0]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
